maj_operand_packer: RTL



---
 rtl/maj_pkg.sv | 26 ++
 rtl/maj_pad_gen.sv | 30 +++
 rtl/maj_operand_packer.sv | 124 ++++++++++++
 3 files changed

// File: rtl/maj_pkg.sv
// Shared definitions for the majority-gate operand path: default width, state enum, pad slot mask.
// Latency: none (package only).
// Backpressure: not applicable.
package maj_pkg;

   localparam int MAJ_M_DEFAULT = 3;

   // Widest operand the pad helpers support; the packer rejects larger M at elaboration.
   localparam int PAD_W = 32;

   typedef enum logic {
      FILL = 1'b0,   // output register empty, collecting bits
      HOLD = 1'b1    // output register holds a word awaiting a_ready
   } maj_state_e;

   // Pad slots of an m-bit word carrying k real bits: positions k..m-1 set.
   function automatic logic [PAD_W-1:0] pad_mask(input int m, input int k);
      logic [PAD_W-1:0] mask;
      mask = '0;
      for (int i = 0; i < PAD_W; i++) begin
         mask[i] = (i >= k) && (i < m);
      end
      return mask;
   endfunction

endpackage

// File: rtl/maj_pad_gen.sv
// Pad vector for a short operand word: k real bits -> M-bit pattern occupying slots k..M-1.
// Latency: combinational. Backpressure: none.
// MAJ_PACK_NEUTRAL_PAD_EN: defined -> odd slots padded with 1, even with 0; undefined -> all pad 0.
module maj_pad_gen
   import maj_pkg::*;
#(
   parameter int M  = MAJ_M_DEFAULT,
   parameter int CW = $clog2(M + 1)
) (
   input  logic [CW-1:0] k_i,
   output logic [M-1:0]  pad_o
);

   logic [PAD_W-1:0] slots;

   // Pattern is tied to absolute bit position: an odd k leaves an even run of
   // balanced 1/0 pad, an even k leaves one surplus 0, so ties resolve to 0.
   always_comb begin
      slots = pad_mask(M, int'(k_i));
      pad_o = '0;
      for (int i = 0; i < M; i++) begin
`ifdef MAJ_PACK_NEUTRAL_PAD_EN
         pad_o[i] = slots[i] & 1'(i % 2);
`else
         pad_o[i] = slots[i] & 1'b0;
`endif
      end
   end

endmodule

// File: rtl/maj_operand_packer.sv
// Packs a bit-serial stream LSB-first into registered M-bit operand words, padding short groups.
// Latency: word valid the cycle after its last bit is accepted; 1 bit/cycle sustained.
// Backpressure: a held word with a_ready low drops in_ready; no bit is accepted or lost.
// Build option MAJ_PACK_NEUTRAL_PAD_EN selects neutral (alternating) padding instead of zeros.
module maj_operand_packer
   import maj_pkg::*;
#(
   parameter int M  = MAJ_M_DEFAULT,
   parameter int CW = $clog2(M + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_bit,
   input  logic          in_valid,
   input  logic          in_last,
   output logic          in_ready,
   output logic [M-1:0]  a,
   output logic [CW-1:0] a_count,
   output logic          a_last,
   output logic          a_valid,
   input  logic          a_ready
);

   if ((M < 3) || ((M % 2) == 0) || (M > PAD_W)) begin : g_bad_m
      $fatal(1, "maj_operand_packer: M must be odd, >= 3 and <= PAD_W");
   end

   maj_state_e    state_q, state_d;
   logic [M-1:0]  fill_q, fill_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [M-1:0]  a_q, a_d;
   logic [CW-1:0] count_q, count_d;
   logic          last_q, last_d;

   logic          accept;
   logic          complete;
   logic [CW-1:0] k_new;
   logic [M-1:0]  pad;
   logic [M-1:0]  word;

   assign a_valid  = (state_q == HOLD);
   assign in_ready = !a_valid || a_ready;
   assign accept   = in_valid && in_ready;
   assign k_new    = CW'(cnt_q + 1'b1);
   assign complete = accept && ((cnt_q == CW'(M - 1)) || in_last);

   maj_pad_gen #(
      .M  (M),
      .CW (CW)
   ) u_pad_gen (
      .k_i   (k_new),
      .pad_o (pad)
   );

   // Fill bits above cnt are always zero, so OR-ing in the new bit and pad is safe.
   assign word = fill_q | (M'(in_bit) << cnt_q) | pad;

   // Fill register and bit counter: store accepted bits, restart on completion.
   always_comb begin
      fill_d = fill_q;
      cnt_d  = cnt_q;
      if (complete) begin
         fill_d = '0;
         cnt_d  = '0;
      end else if (accept) begin
         fill_d[cnt_q] = in_bit;
         cnt_d         = k_new;
      end
   end

   // Output FSM: load on completion, release on a_ready; back-to-back load keeps HOLD.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      count_d = count_q;
      last_d  = last_q;
      case (state_q)
         FILL: begin
            if (complete) begin
               state_d = HOLD;
               a_d     = word;
               count_d = k_new;
               last_d  = in_last;
            end
         end
         HOLD: begin
            if (a_ready) begin
               if (complete) begin
                  a_d     = word;
                  count_d = k_new;
                  last_d  = in_last;
               end else begin
                  state_d = FILL;
               end
            end
         end
         default: state_d = FILL;
      endcase
   end

   // State registers with synchronous reset discarding any partial or held word.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= FILL;
         fill_q  <= '0;
         cnt_q   <= '0;
         a_q     <= '0;
         count_q <= '0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         fill_q  <= fill_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         count_q <= count_d;
         last_q  <= last_d;
      end
   end

   assign a       = a_q;
   assign a_count = count_q;
   assign a_last  = last_q;

endmodule
